// File: rtl/rvv_pkg.sv
// rvv_pkg: shared RVV constants, collector state encoding and derived widths
package rvv_pkg;
  localparam logic [1:0] OP_VV = 2'd0;
  localparam logic [1:0] OP_VX = 2'd1;
  localparam logic [1:0] OP_VI = 2'd2;
  localparam logic [2:0] SEW_8 = 3'b000;
  localparam logic [2:0] SEW_16 = 3'b001;
  localparam logic [2:0] SEW_32 = 3'b010;
  localparam logic [2:0] SEW_64 = 3'b011;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam int VLEN_DEF = 128;
  localparam int LANE_WIDTH_DEF = 3;
  localparam int NB_LANES_DEF = 2;
  localparam int SHIFTED_LANE_WIDTH = 1 << LANE_WIDTH_DEF;
  localparam int CHUNKS = VLEN_DEF >> LANE_WIDTH_DEF;
  function automatic logic [15:0] sew_bits(input logic [2:0] vsew);
    return 16'd8 << vsew;
  endfunction
endpackage

// File: rtl/rvv_wb_chunk_merge.sv
// rvv_wb_chunk_merge: merges one cycle of lane chunks into the vd image with range/duplicate checks
module rvv_wb_chunk_merge #(
  parameter int VLEN = 128,
  parameter int LANE_WIDTH = 3,
  parameter int NB_LANES = 2
) (
  input  logic [VLEN-1:0]               buf_i,
  input  logic [(VLEN>>LANE_WIDTH)-1:0] map_i,
  input  logic [15:0]                   target_i,
  input  logic [NB_LANES-1:0]           lane_valid_i,
  input  logic [NB_LANES*64-1:0]        lane_data_i,
  input  logic [NB_LANES*10-1:0]        lane_index_i,
  output logic [VLEN-1:0]               buf_o,
  output logic [(VLEN>>LANE_WIDTH)-1:0] map_o,
  output logic [15:0]                   delta_o,
  output logic                          err_o
);
  localparam int CW = 1 << LANE_WIDTH;
  localparam int PW = $clog2(VLEN);
  logic [NB_LANES-1:0] ok;
  logic unused_data;
  assign unused_data = ^lane_data_i;
  // lanes applied in ascending order so the highest lane wins a shared index;
  // the bitmap is updated as we go so a duplicate only counts once
  always_comb begin
    buf_o = buf_i;
    map_o = map_i;
    delta_o = '0;
    err_o = 1'b0;
    ok = '0;
    for (int i = 0; i < NB_LANES; i++) begin
      if (lane_valid_i[i]) begin
        ok[i] = lane_index_i[i*10 +: LANE_WIDTH] == '0 && 16'(lane_index_i[i*10 +: 10]) < target_i;
        err_o = err_o | !ok[i];
        for (int j = 0; j < i; j++)
          err_o = err_o | (ok[i] && ok[j] && lane_index_i[j*10 +: 10] == lane_index_i[i*10 +: 10]);
        if (ok[i]) begin
          buf_o[lane_index_i[i*10 +: PW] +: CW] = lane_data_i[i*64 +: CW];
          if (!map_o[lane_index_i[i*10+LANE_WIDTH +: PW-LANE_WIDTH]]) begin
            map_o[lane_index_i[i*10+LANE_WIDTH +: PW-LANE_WIDTH]] = 1'b1;
            delta_o = delta_o + 16'(CW);
          end
        end
      end
    end
  end
endmodule

// File: rtl/rvv_wb_collect.sv
// rvv_wb_collect: gathers lane result chunks into a vd image and issues one register-file write
module rvv_wb_collect
  import rvv_pkg::*;
#(
  parameter int VLEN = VLEN_DEF,
  parameter int LANE_WIDTH = LANE_WIDTH_DEF,
  parameter int NB_LANES = NB_LANES_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [9:0]             vl,
  input  logic [2:0]             vsew,
  input  logic [4:0]             vd_addr,
  input  logic [VLEN-1:0]        old_vd,
  input  logic [NB_LANES-1:0]    lane_valid,
  input  logic [NB_LANES*64-1:0] lane_data,
  input  logic [NB_LANES*10-1:0] lane_index,
  output logic                   busy,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [4:0]             wb_addr,
  output logic [VLEN-1:0]        wb_data,
  output logic [VLEN/8-1:0]      wb_be,
  output logic                   done,
  output logic                   err
);
  localparam int NCH = VLEN >> LANE_WIDTH;
  localparam logic [15:0] VLEN16 = 16'(VLEN);
  logic [1:0] state_q, state_d;
  logic [VLEN-1:0] buf_q, buf_d, m_buf;
  logic [NCH-1:0] map_q, map_d, m_map;
  logic [15:0] cnt_q, cnt_d, tgt_q, tgt_d, m_delta, raw_tgt, cnt_next;
  logic [4:0] addr_q, addr_d;
  logic err_q, err_d, done_q, done_d, m_err;
  rvv_wb_chunk_merge #(.VLEN(VLEN), .LANE_WIDTH(LANE_WIDTH), .NB_LANES(NB_LANES)) u_merge (
    .buf_i(buf_q), .map_i(map_q), .target_i(tgt_q),
    .lane_valid_i(lane_valid), .lane_data_i(lane_data), .lane_index_i(lane_index),
    .buf_o(m_buf), .map_o(m_map), .delta_o(m_delta), .err_o(m_err)
  );
  assign raw_tgt = 16'(vl) << ({1'b0, vsew} + 4'd3);
  assign cnt_next = cnt_q + m_delta;
  assign busy = state_q != S_IDLE;
  assign wb_valid = state_q == S_WRITE;
  assign wb_addr = addr_q;
  assign wb_data = buf_q;
  assign done = done_q;
  assign err = err_q;
  // byte enables cover every byte that starts below the target length
  always_comb for (int b = 0; b < VLEN/8; b++) wb_be[b] = 16'(8*b) < tgt_q;
  // next-state: start latch, per-cycle chunk merge, write handshake
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    map_d = map_q;
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    addr_d = addr_q;
    err_d = err_q;
    done_d = 1'b0;
    if (state_q == S_IDLE && start) begin
      addr_d = vd_addr;
      buf_d = old_vd;
      map_d = '0;
      cnt_d = '0;
      tgt_d = raw_tgt > VLEN16 ? VLEN16 : raw_tgt;
      err_d = raw_tgt > VLEN16;
      state_d = vl == '0 ? S_IDLE : S_COLLECT;
      done_d = vl == '0;
    end else if (state_q == S_COLLECT) begin
      buf_d = m_buf;
      map_d = m_map;
      cnt_d = cnt_next;
      err_d = err_q | m_err;
      state_d = cnt_next == tgt_q ? S_WRITE : S_COLLECT;
    end else if (state_q == S_WRITE) begin
      err_d = err_q | (|lane_valid);
      state_d = wb_ready ? S_IDLE : S_WRITE;
      done_d = wb_ready;
    end
  end
  // state registers with synchronous reset abandoning any instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q <= '0;
      map_q <= '0;
      cnt_q <= '0;
      tgt_q <= '0;
      addr_q <= '0;
      err_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      map_q <= map_d;
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      addr_q <= addr_d;
      err_q <= err_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_rvv_wb_collect.sv
// tb_rvv_wb_collect: directed self-checking bench for the writeback collector
module tb_rvv_wb_collect;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, wb_ready = 1'b0;
  logic [9:0] vl = '0;
  logic [2:0] vsew = '0;
  logic [4:0] vd_addr = '0;
  logic [127:0] old_vd = '0;
  logic [1:0] lane_valid = '0;
  logic [127:0] lane_data = '0;
  logic [19:0] lane_index = '0;
  logic busy, wb_valid, done, err;
  logic [4:0] wb_addr;
  logic [127:0] wb_data;
  logic [15:0] wb_be;
  int errors = 0, checks = 0;
  rvv_wb_collect dut (
    .clk(clk), .reset(reset), .start(start), .vl(vl), .vsew(vsew), .vd_addr(vd_addr),
    .old_vd(old_vd), .lane_valid(lane_valid), .lane_data(lane_data), .lane_index(lane_index),
    .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_be(wb_be), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [1:0] v, input logic [7:0] d0, input logic [9:0] i0,
                      input logic [7:0] d1, input logic [9:0] i1);
    lane_valid = v;
    lane_data = {56'd0, d1, 56'd0, d0};
    lane_index = {i1, i0};
    tick;
    lane_valid = '0;
  endtask
  task automatic begin_instr(input logic [9:0] l, input logic [2:0] s, input logic [4:0] a,
                             input logic [127:0] old);
    start = 1'b1; vl = l; vsew = s; vd_addr = a; old_vd = old;
    tick;
    start = 1'b0;
  endtask
  task automatic run_full(input int stall);
    begin_instr(10'd16, 3'b000, 5'd3, '0);
    chk("s1_busy", busy, 1);
    chk("s1_err0", err, 0);
    for (int k = 0; k < 8; k++) begin
      chk("s1_novalid", wb_valid, 0);
      beat(2'b11, 8'(2*k), 10'(16*k), 8'(2*k+1), 10'(16*k+8));
    end
    for (int s = 0; s <= stall; s++) begin
      chk("s1_valid", wb_valid, 1);
      chk("s1_data", wb_data, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("s1_be", wb_be, 16'hFFFF);
      chk("s1_addr", wb_addr, 5'd3);
      chk("s1_nodone", done, 0);
      if (s == stall) wb_ready = 1'b1;
      tick;
    end
    wb_ready = 1'b0;
    chk("s1_done", done, 1);
    chk("s1_valid_low", wb_valid, 0);
    chk("s1_idle", busy, 0);
    chk("s1_err", err, 0);
    tick;
    chk("s1_done_pulse", done, 0);
  endtask
  initial begin
    tick; tick;
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", wb_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_be", wb_be, 0);
    run_full(0);
    run_full(3);
    begin_instr(10'd2, 3'b010, 5'd7, {16{8'hAA}});
    for (int k = 0; k < 4; k++) beat(2'b11, 8'h11, 10'(16*k), 8'h11, 10'(16*k+8));
    chk("s2_valid", wb_valid, 1);
    chk("s2_data", wb_data, {{8{8'hAA}}, {8{8'h11}}});
    chk("s2_be", wb_be, 16'h00FF);
    chk("s2_addr", wb_addr, 5'd7);
    chk("s2_err0", err, 0);
    beat(2'b01, 8'h99, 10'd0, 8'h00, 10'd0);
    chk("s2_write_lane_err", err, 1);
    chk("s2_data_held", wb_data, {{8{8'hAA}}, {8{8'h11}}});
    wb_ready = 1'b1; tick; wb_ready = 1'b0;
    chk("s2_done", done, 1);
    begin_instr(10'd2, 3'b010, 5'd9, {16{8'h5A}});
    chk("s4_start_clears_err", err, 0);
    beat(2'b01, 8'h01, 10'd0, 8'h00, 10'd0);
    beat(2'b01, 8'h02, 10'd0, 8'h00, 10'd0);
    chk("s4_rewrite_noerr", err, 0);
    beat(2'b01, 8'h33, 10'd64, 8'h00, 10'd0);
    chk("s4_range_err", err, 1);
    beat(2'b11, 8'h77, 10'd8, 8'h77, 10'd16);
    beat(2'b11, 8'h77, 10'd24, 8'h77, 10'd32);
    beat(2'b11, 8'h77, 10'd40, 8'h77, 10'd48);
    chk("s4_count_once", wb_valid, 0);
    beat(2'b01, 8'h77, 10'd56, 8'h00, 10'd0);
    chk("s4_valid", wb_valid, 1);
    chk("s4_data", wb_data, {{8{8'h5A}}, {7{8'h77}}, 8'h02});
    chk("s4_err_sticky", err, 1);
    wb_ready = 1'b1; tick; wb_ready = 1'b0;
    chk("s4_done", done, 1);
    begin_instr(10'd0, 3'b000, 5'd1, '0);
    chk("s5_done", done, 1);
    chk("s5_novalid", wb_valid, 0);
    chk("s5_notbusy", busy, 0);
    tick;
    chk("s5_pulse", done, 0);
    chk("s5_novalid2", wb_valid, 0);
    begin_instr(10'd2, 3'b000, 5'd2, '0);
    beat(2'b11, 8'hAA, 10'd0, 8'hBB, 10'd0);
    chk("s7_dup_err", err, 1);
    chk("s7_dup_count_once", wb_valid, 0);
    beat(2'b01, 8'hCC, 10'd8, 8'h00, 10'd0);
    chk("s7_valid", wb_valid, 1);
    chk("s7_data", wb_data, 128'hCCBB);
    chk("s7_be", wb_be, 16'h0003);
    wb_ready = 1'b1; tick; wb_ready = 1'b0;
    begin_instr(10'd20, 3'b000, 5'd4, '0);
    chk("s8_clamp_err", err, 1);
    chk("s8_busy", busy, 1);
    chk("s8_be_clamped", wb_be, 16'hFFFF);
    reset = 1'b1; tick; reset = 1'b0;
    begin_instr(10'd16, 3'b000, 5'd3, '0);
    beat(2'b11, 8'h00, 10'd0, 8'h01, 10'd8);
    beat(2'b01, 8'h02, 10'd16, 8'h00, 10'd0);
    reset = 1'b1; tick; reset = 1'b0;
    chk("s6_busy", busy, 0);
    chk("s6_valid", wb_valid, 0);
    chk("s6_err", err, 0);
    chk("s6_data", wb_data, 0);
    tick;
    chk("s6_nodone", done, 0);
    run_full(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
